// File: rtl/dsam_ctrl.sv
// Sequencing controller for the DSAM encoder datapath: handshake, pipeline
// enable, FIFO strobes, raw/differential select, fill and resync framing.
//
// state  | meaning
// IDLE   | stopped; pipeline drains; enable starts a session with enc_clear
// FILL   | first frame after start, passed raw, FIFO written only
// RUN    | differential frames, FIFO read and written
// RESYNC | one raw frame for decoder re-lock, FIFO still read and written
module dsam_ctrl #(
  parameter int CHANNELS        = 256,
  parameter int CHAN_WIDTH      = 8,
  parameter int RESYNC_FRAMES   = 64,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       enc_ce,
  output logic                       enc_clear,
  output logic                       diff_sel,
  output logic                       fifo_write,
  output logic                       fifo_read,
  output logic [CHAN_WIDTH-1:0]      chan_idx,
  output logic                       frame_start,
  output logic                       raw_flag,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int RW = (RESYNC_FRAMES > 0) ? $clog2(RESYNC_FRAMES + 1) : 1;
  localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_RESYNC} state_t;

  state_t                     r_state, w_state_nxt;
  logic [CHAN_WIDTH-1:0]      r_chan, w_chan_nxt;
  logic [FRAME_CNT_WIDTH-1:0] r_fc, w_fc_nxt;
  logic [RW-1:0]              r_rc, w_rc_nxt, w_rc_inc;
  logic                       r_v1, r_v2, r_raw1, r_raw2;
  logic                       w_adv, w_acc, w_frame_end, w_clear, w_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
      r_fc    <= '0;
      r_rc    <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_raw1  <= 1'b0;
      r_raw2  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
      r_fc    <= w_fc_nxt;
      r_rc    <= w_rc_nxt;
      if (w_adv) begin
        r_v1   <= w_acc;
        r_v2   <= r_v1;
        r_raw1 <= w_acc & ~w_diff;
        r_raw2 <= r_raw1;
      end
    end
  end

  always_comb begin
    w_adv       = out_ready | ~r_v2;
    w_acc       = in_valid & w_adv & (r_state != S_IDLE);
    w_frame_end = w_acc & (r_chan == LAST_CHAN);
    w_diff      = (r_state == S_RUN);
    w_rc_inc    = r_rc + 1'b1;
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_fc_nxt    = r_fc;
    w_rc_nxt    = r_rc;
    w_clear     = 1'b0;
    if (w_acc) w_chan_nxt = w_frame_end ? '0 : r_chan + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_chan_nxt = '0;
        if (enable) begin
          w_state_nxt = S_FILL;
          w_clear     = 1'b1;
          w_fc_nxt    = '0;
          w_rc_nxt    = '0;
        end
      end
      S_FILL: begin
        if (w_frame_end) w_state_nxt = enable ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (w_frame_end) begin
          w_fc_nxt = r_fc + 1'b1;
          w_rc_nxt = w_rc_inc;
          // disable wins over a resync falling due on the same frame end
          if (!enable) begin
            w_state_nxt = S_IDLE;
          end else if (RESYNC_FRAMES != 0 && w_rc_inc == RW'(RESYNC_FRAMES)) begin
            w_state_nxt = S_RESYNC;
            w_rc_nxt    = '0;
          end
        end
      end
      S_RESYNC: begin
        if (w_frame_end) begin
          w_fc_nxt    = r_fc + 1'b1;
          w_state_nxt = enable ? S_RUN : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // combinational strobes are forced low while reset is held
  assign enc_ce      = w_adv & ~reset;
  assign enc_clear   = w_clear & ~reset;
  assign in_ready    = w_adv & (r_state != S_IDLE);
  assign out_valid   = r_v2;
  assign raw_flag    = r_raw2;
  assign diff_sel    = w_diff;
  assign fifo_write  = w_acc;
  assign fifo_read   = w_acc & ((r_state == S_RUN) | (r_state == S_RESYNC));
  assign chan_idx    = r_chan;
  assign frame_start = w_acc & (r_chan == '0);
  assign frame_count = r_fc;

endmodule

// File: tb/tb_dsam_ctrl.sv
// Self-checking bench for dsam_ctrl: two instances (resync every 2 frames and
// resync disabled) share stimulus and are compared against a frame-level model.
module tb_dsam_ctrl;

  logic clk = 1'b0;
  logic reset, enable, in_valid, out_ready;

  logic       a_in_ready, a_out_valid, a_enc_ce, a_enc_clear, a_diff_sel;
  logic       a_fifo_write, a_fifo_read, a_frame_start, a_raw_flag;
  logic [1:0] a_chan_idx;
  logic [15:0] a_frame_count;
  logic       b_in_ready, b_out_valid, b_enc_ce, b_enc_clear, b_diff_sel;
  logic       b_fifo_write, b_fifo_read, b_frame_start, b_raw_flag;
  logic [1:0] b_chan_idx;
  logic [15:0] b_frame_count;

  dsam_ctrl #(.CHANNELS(4), .CHAN_WIDTH(2), .RESYNC_FRAMES(2), .FRAME_CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .enc_ce(a_enc_ce), .enc_clear(a_enc_clear), .diff_sel(a_diff_sel),
    .fifo_write(a_fifo_write), .fifo_read(a_fifo_read), .chan_idx(a_chan_idx),
    .frame_start(a_frame_start), .raw_flag(a_raw_flag), .frame_count(a_frame_count));

  dsam_ctrl #(.CHANNELS(4), .CHAN_WIDTH(2), .RESYNC_FRAMES(0), .FRAME_CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .enc_ce(b_enc_ce), .enc_clear(b_enc_clear), .diff_sel(b_diff_sel),
    .fifo_write(b_fifo_write), .fifo_read(b_fifo_read), .chan_idx(b_chan_idx),
    .frame_start(b_frame_start), .raw_flag(b_raw_flag), .frame_count(b_frame_count));

  always #5 clk = ~clk;

  // model: session active flag, channel, frame index within session (0 = fill)
  bit          m_active;
  int          m_chan, m_frame;
  logic [15:0] m_fc;
  typedef struct {int age; bit ra; bit rb;} item_t;
  item_t       q[$];
  int          checks = 0, errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit raw_of(int f, int rf);
    return (f == 0) || (rf != 0 && (f % (rf + 1)) == 0);
  endfunction

  task automatic model_reset();
    m_active = 0; m_chan = 0; m_frame = 0; m_fc = '0;
    q.delete();
  endtask

  task automatic zero_chk(string tag);
    chk({tag, "_a_in_ready"}, a_in_ready, 0);
    chk({tag, "_a_out_valid"}, a_out_valid, 0);
    chk({tag, "_a_enc_ce"}, a_enc_ce, 0);
    chk({tag, "_a_enc_clear"}, a_enc_clear, 0);
    chk({tag, "_a_diff_sel"}, a_diff_sel, 0);
    chk({tag, "_a_fifo_write"}, a_fifo_write, 0);
    chk({tag, "_a_fifo_read"}, a_fifo_read, 0);
    chk({tag, "_a_chan_idx"}, a_chan_idx, 0);
    chk({tag, "_a_frame_start"}, a_frame_start, 0);
    chk({tag, "_a_raw_flag"}, a_raw_flag, 0);
    chk({tag, "_a_frame_count"}, a_frame_count, 0);
    chk({tag, "_b_enc_ce"}, b_enc_ce, 0);
    chk({tag, "_b_frame_count"}, b_frame_count, 0);
  endtask

  task automatic cyc();
    bit e_ov, e_adv, e_acc, e_ra, e_rb, en;
    @(negedge clk);
    e_ov  = (q.size() > 0) && (q[0].age == 2);
    e_adv = out_ready | ~e_ov;
    e_acc = in_valid & e_adv & m_active;
    e_ra  = e_ov ? q[0].ra : 1'b0;
    e_rb  = e_ov ? q[0].rb : 1'b0;
    chk("in_ready", a_in_ready, e_adv & m_active);
    chk("out_valid", a_out_valid, e_ov);
    chk("enc_ce", a_enc_ce, e_adv);
    chk("enc_clear", a_enc_clear, !m_active && enable);
    chk("diff_sel", a_diff_sel, m_active && !raw_of(m_frame, 2));
    chk("fifo_write", a_fifo_write, e_acc);
    chk("fifo_read", a_fifo_read, e_acc && m_frame != 0);
    chk("chan_idx", a_chan_idx, m_chan);
    chk("frame_start", a_frame_start, e_acc && m_chan == 0);
    chk("raw_flag", a_raw_flag, e_ra);
    chk("frame_count", a_frame_count, m_fc);
    chk("b_out_valid", b_out_valid, e_ov);
    chk("b_diff_sel", b_diff_sel, m_active && !raw_of(m_frame, 0));
    chk("b_fifo_read", b_fifo_read, e_acc && m_frame != 0);
    chk("b_raw_flag", b_raw_flag, e_rb);
    chk("b_frame_count", b_frame_count, m_fc);
    en = enable;
    @(posedge clk);
    if (e_adv) begin
      if (q.size() > 0 && q[0].age == 2) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (e_acc) q.push_back('{age: 1, ra: raw_of(m_frame, 2), rb: raw_of(m_frame, 0)});
    end
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_chan = 0; m_frame = 0; m_fc = '0;
      end
    end else if (e_acc) begin
      if (m_chan == 3) begin
        m_chan = 0;
        if (m_frame != 0) m_fc++;
        if (en) m_frame++;
        else m_active = 0;
      end else begin
        m_chan++;
      end
    end
    #1;
  endtask

  initial begin
    int c;
    model_reset();
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    zero_chk("rst");
    enable = 1'b1; in_valid = 1'b1;
    #1;
    zero_chk("rst_en");
    @(posedge clk);
    #3 reset = 1'b0;

    // fill, run, run, resync with continuous traffic
    repeat (17) cyc();
    chk("fc_after_resync", a_frame_count, 3);
    chk("b_fc_after_4", b_frame_count, 3);

    // output stall mid-frame
    for (int i = 0; i < 20 && m_chan != 1; i++) cyc();
    chk("wait_chan1_stall", m_chan, 1);
    c = a_chan_idx;
    out_ready = 1'b0;
    repeat (5) cyc();
    chk("stall_chan_hold", a_chan_idx, c);
    out_ready = 1'b1;
    repeat (10) cyc();

    // random valid/ready traffic
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b1; out_ready = 1'b1;

    // enable drop mid-frame, drain, restart
    for (int i = 0; i < 20 && !(m_active && m_chan == 1); i++) cyc();
    chk("wait_chan1_dis", m_chan, 1);
    enable = 1'b0;
    repeat (8) cyc();
    chk("idle_in_ready", a_in_ready, 0);
    chk("idle_drained", a_out_valid, 0);
    enable = 1'b1;
    repeat (10) cyc();

    // asynchronous reset mid-run, then resync-disabled frame count
    for (int i = 0; i < 20 && !(m_active && m_frame >= 1); i++) cyc();
    chk("wait_run", m_active && m_frame >= 1, 1);
    #2 reset = 1'b1;
    #1 zero_chk("async_rst");
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (45) cyc();
    chk("b_fc_10", b_frame_count, 10);
    chk("a_fc_10", a_frame_count, 10);

    // random traffic with occasional enable drops
    repeat (1500) begin
      enable    = ($urandom_range(0, 15) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
